// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA sequencer.
// Contents: default counter width, external counter load polarity,
// and the sequencer state encoding.
package dma_pkg;

  localparam int unsigned DMA_W = 10;

  // External counters load while their nload pin is low.
  localparam logic LOAD_ON  = 1'b0;
  localparam logic LOAD_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REQ    = 3'd2,
    ST_BEAT   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dma_settle_timer.sv
// Post-beat settle timer: counts SETTLE_CYC cycles from a start pulse so the
// sequencer only samples the word-counter carry once the counters have moved.
// Ports:
//   clk, nMR   clock, asynchronous active-low reset
//   start_i    load the timer (issued on the cycle leaving BEAT)
//   expire_o   registered; high from the last settle cycle until restarted
module dma_settle_timer #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic nMR,
  input  logic start_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire_q;

  // Load SETTLE_CYC-1 so the first settle cycle already sees the loaded count.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CW'(SETTLE_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nMR) begin
    if (!nMR) begin
      cnt_q    <= '0;
      expire_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == '0);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/dma_channel_ctrl.sv
// Single-channel DMA sequencer driving external address (AC) and word (WC)
// loadable counters. Latches a descriptor on start, loads both counters,
// arbitrates for the bus and serves one device beat per request until WC
// reaches zero.
// Optional feature: define DMA_AUTOINIT_EN to reload and repeat the latched
// descriptor after terminal count when autoinit was set at start.
// Ports:
//   clk, nMR                 clock, asynchronous active-low master reset
//   start, abort             transfer start (IDLE only), synchronous abort
//   base_addr, xfer_len      descriptor address and beat count
//   addr_dec, autoinit       address direction, auto-reinitialise request
//   dreq, hlda               device request, bus grant
//   ac/wc_load_done, wc_carry   counter status
//   ac_data/nload/en/dir     address counter controls
//   wc_data/nload/en         word counter controls (WC counts down externally)
//   hrq, dack                bus hold request, device acknowledge
//   busy, done, err          status; done/err are single-cycle pulses
// All outputs are registered.
module dma_channel_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned W          = DMA_W,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         nMR,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] base_addr,
  input  logic [W-1:0] xfer_len,
  input  logic         addr_dec,
  input  logic         autoinit,
  input  logic         dreq,
  input  logic         hlda,
  input  logic         ac_load_done,
  input  logic         wc_load_done,
  input  logic         wc_carry,
  output logic [W-1:0] ac_data,
  output logic         ac_nload,
  output logic         ac_en,
  output logic         ac_dir,
  output logic [W-1:0] wc_data,
  output logic         wc_nload,
  output logic         wc_en,
  output logic         hrq,
  output logic         dack,
  output logic         busy,
  output logic         done,
  output logic         err
);

  dma_state_e   state_q, state_d;
  logic [W-1:0] base_q, base_d;
  logic [W-1:0] len_q, len_d;
  logic         dir_q, dir_d;
  logic         ac_flag_q, ac_flag_d;
  logic         wc_flag_q, wc_flag_d;
  logic         ac_nload_q, ac_nload_d;
  logic         wc_nload_q, wc_nload_d;
  logic         en_q, en_d;
  logic         hrq_q, hrq_d;
  logic         dack_q, dack_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         settle_start_c;
  logic         settle_expire;

`ifdef DMA_AUTOINIT_EN
  logic         auto_q, auto_d;
`else
  logic         unused_autoinit;
  assign unused_autoinit = autoinit;
`endif

  dma_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk      (clk),
    .nMR      (nMR),
    .start_i  (settle_start_c),
    .expire_o (settle_expire)
  );

  // Next state, then registered outputs decoded from the next state so they
  // line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    dir_d      = dir_q;
    ac_flag_d  = ac_flag_q;
    wc_flag_d  = wc_flag_q;
    ac_nload_d = LOAD_OFF;
    wc_nload_d = LOAD_OFF;
    en_d       = 1'b0;
    hrq_d      = 1'b0;
    dack_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef DMA_AUTOINIT_EN
    auto_d     = auto_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Abort in IDLE masks start, including the zero-length error.
        if (start && !abort) begin
          if (xfer_len != '0) begin
            base_d  = base_addr;
            len_d   = xfer_len;
            dir_d   = ~addr_dec;
`ifdef DMA_AUTOINIT_EN
            auto_d  = autoinit;
`endif
            state_d = ST_LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // Load-done strobes may arrive in different cycles; remember each.
        ac_flag_d = ac_flag_q | ac_load_done;
        wc_flag_d = wc_flag_q | wc_load_done;
        if (ac_flag_d && wc_flag_d) begin
          ac_flag_d = 1'b0;
          wc_flag_d = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dreq && hlda) begin
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_expire) begin
          state_d = wc_carry ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
`ifdef DMA_AUTOINIT_EN
        state_d = auto_q ? ST_LOAD : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      ac_flag_d = 1'b0;
      wc_flag_d = 1'b0;
    end

    settle_start_c = (state_q == ST_BEAT) && (state_d == ST_SETTLE);

    unique case (state_d)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        busy_d     = 1'b1;
        ac_nload_d = LOAD_ON;
        wc_nload_d = LOAD_ON;
      end
      ST_REQ: begin
        busy_d = 1'b1;
        hrq_d  = dreq;
      end
      ST_BEAT: begin
        busy_d = 1'b1;
        hrq_d  = 1'b1;
        dack_d = 1'b1;
        en_d   = 1'b1;
      end
      ST_SETTLE: begin
        busy_d = 1'b1;
        hrq_d  = hrq_q;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge nMR) begin
    if (!nMR) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b1;
      ac_flag_q  <= 1'b0;
      wc_flag_q  <= 1'b0;
      ac_nload_q <= LOAD_OFF;
      wc_nload_q <= LOAD_OFF;
      en_q       <= 1'b0;
      hrq_q      <= 1'b0;
      dack_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DMA_AUTOINIT_EN
      auto_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      ac_flag_q  <= ac_flag_d;
      wc_flag_q  <= wc_flag_d;
      ac_nload_q <= ac_nload_d;
      wc_nload_q <= wc_nload_d;
      en_q       <= en_d;
      hrq_q      <= hrq_d;
      dack_q     <= dack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef DMA_AUTOINIT_EN
      auto_q     <= auto_d;
`endif
    end
  end

  assign ac_data  = base_q;
  assign ac_nload = ac_nload_q;
  assign ac_en    = en_q;
  assign ac_dir   = dir_q;
  assign wc_data  = len_q;
  assign wc_nload = wc_nload_q;
  assign wc_en    = en_q;
  assign hrq      = hrq_q;
  assign dack     = dack_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
